// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial A - B using one full-subtract cell, LSB first
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a subtraction (ignored while busy)
//   a, b       minuend / subtrahend, captured on accept
//   busy       high while shifting
//   done       one-cycle pulse when diff/borrow_out are newly valid
//   diff       registered A - B (mod 2^WIDTH)
//   borrow_out final borrow, high iff A < B
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] areg, breg, rreg;
    logic brw, m, n, d, bout, accept, last;
    logic [5:0] cnt;
    assign m      = areg[0];
    assign n      = breg[0];
    assign d      = m ^ n ^ brw;
    assign bout   = (~m & n) | (~(m ^ n) & brw);
    assign accept = start && state != SHIFT;
    assign last   = state == SHIFT && cnt == 6'(WIDTH - 1);
    assign busy   = state == SHIFT;
    assign done   = state == DONE;
    always_comb begin
        state_nx = state;
        state_nx = (state == SHIFT) ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // rreg needs no clearing on accept: all WIDTH bits are refilled by the shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg       <= '0;
            breg       <= '0;
            rreg       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            areg <= a;
            breg <= b;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            areg <= areg >> 1;
            breg <= breg >> 1;
            rreg <= {d, rreg[WIDTH-1:1]};
            brw  <= bout;
            cnt  <= cnt + 6'd1;
            if (last) begin
                diff       <= {d, rreg[WIDTH-1:1]};
                borrow_out <= bout;
            end
        end
    end
endmodule
